// File: rtl/comp_csr_master.sv
// ---------------------------------------------------------------------------
// comp_csr_master
//
// Avalon-MM initiator that services the comparator CSR slave in hardware.
// It does two jobs:
//   * Pointer programming: on a cfg request it writes the task's end pointer
//     and then its start pointer into the comparator's pointer directories.
//   * Interrupt service: when irq is high it reads the exception, success and
//     fail registers, clears the exception register (which drops irq and
//     clears the vectors in the comparator) and reports the outcome on a
//     one-cycle result strobe.
//
// Ports
//   clk, reset_n      clock and synchronous active-low reset
//   cfg_valid/ready   pointer-config handshake (ready only in the accept cycle)
//   cfg_task/start/end task id and CRC RAM pointers to program
//   irq               comparator interrupt, level sensitive
//   av_*              Avalon-MM initiator port to the comparator CSR slave
//   res_valid         one-cycle strobe when a service completes
//   res_task/collision decoded exception register fields
//   res_succ/fail_vec success and fail register snapshots
//   err_timeout       sticky: a transfer was abandoned after a waitrequest stall
// ---------------------------------------------------------------------------
module comp_csr_master #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 32,
    parameter int                RAM_AW     = 10,
    parameter int                KEY_W      = 4,
    parameter logic [ADDR_W-1:0] EXC_OFF    = 8'h00,
    parameter logic [ADDR_W-1:0] SUCC_OFF   = 8'h01,
    parameter logic [ADDR_W-1:0] FAIL_OFF   = 8'h02,
    parameter logic [ADDR_W-1:0] START_BASE = 8'h10,
    parameter logic [ADDR_W-1:0] END_BASE   = 8'h20,
    parameter int                EXC_EX_BIT = 4,
    parameter int                TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [KEY_W-1:0]      cfg_task,
    input  logic [RAM_AW-1:0]     cfg_start,
    input  logic [RAM_AW-1:0]     cfg_end,
    input  logic                  irq,
    output logic [ADDR_W-1:0]     av_address,
    output logic                  av_read,
    output logic                  av_write,
    output logic [DATA_W-1:0]     av_writedata,
    input  logic [DATA_W-1:0]     av_readdata,
    input  logic                  av_waitrequest,
    output logic                  res_valid,
    output logic [KEY_W-1:0]      res_task,
    output logic                  res_collision,
    output logic [2**KEY_W-1:0]   res_succ_vec,
    output logic [2**KEY_W-1:0]   res_fail_vec,
    output logic                  err_timeout
);

    localparam int NT    = 2**KEY_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_END,
        S_WR_START,
        S_RD_EXC,
        S_RD_SUCC,
        S_RD_FAIL,
        S_WR_CLR,
        S_REPORT,
        S_GAP
    } state_t;

    state_t             state_q, state_d;

    // Set for the first cycle of a transfer state entered straight from a
    // completed transfer, so the strobes drop for one cycle between transfers.
    logic               bubble_q, bubble_d;

    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               err_q, err_d;

    logic [KEY_W-1:0]   cfg_task_q, cfg_task_d;
    logic [RAM_AW-1:0]  cfg_start_q, cfg_start_d;
    logic [RAM_AW-1:0]  cfg_end_q, cfg_end_d;

    // Working copies of the registers read during a service. They are only
    // published to res_* once the clear write has completed, so an aborted
    // service never disturbs the previously reported result.
    logic [KEY_W-1:0]   exc_task_q, exc_task_d;
    logic               exc_coll_q, exc_coll_d;
    logic [NT-1:0]      succ_q, succ_d;
    logic [NT-1:0]      fail_q, fail_d;

    logic [KEY_W-1:0]   res_task_q, res_task_d;
    logic               res_coll_q, res_coll_d;
    logic [NT-1:0]      res_succ_q, res_succ_d;
    logic [NT-1:0]      res_fail_q, res_fail_d;

    logic               xfer_active;
    logic               xfer_done;
    logic               xfer_stall;
    logic               timeout_hit;

    // Only the low vector bits and the exception fields of the read data are
    // meaningful; the rest of the word is deliberately ignored.
    logic               readdata_unused;
    assign readdata_unused = ^av_readdata;

    assign xfer_done   = xfer_active && !av_waitrequest;
    assign xfer_stall  = xfer_active && av_waitrequest;
    // The counter holds the number of stall cycles already seen; the stall
    // that would bring it to TIMEOUT is the one that abandons the transfer.
    assign timeout_hit = xfer_stall && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            bubble_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bubble_q <= bubble_d;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            cfg_task_q  <= '0;
            cfg_start_q <= '0;
            cfg_end_q   <= '0;
            exc_task_q  <= '0;
            exc_coll_q  <= 1'b0;
            succ_q      <= '0;
            fail_q      <= '0;
            res_task_q  <= '0;
            res_coll_q  <= 1'b0;
            res_succ_q  <= '0;
            res_fail_q  <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            cfg_task_q  <= cfg_task_d;
            cfg_start_q <= cfg_start_d;
            cfg_end_q   <= cfg_end_d;
            exc_task_q  <= exc_task_d;
            exc_coll_q  <= exc_coll_d;
            succ_q      <= succ_d;
            fail_q      <= fail_d;
            res_task_q  <= res_task_d;
            res_coll_q  <= res_coll_d;
            res_succ_q  <= res_succ_d;
            res_fail_q  <= res_fail_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        bubble_d    = 1'b0;
        wait_cnt_d  = '0;
        err_d       = err_q;
        cfg_task_d  = cfg_task_q;
        cfg_start_d = cfg_start_q;
        cfg_end_d   = cfg_end_q;
        exc_task_d  = exc_task_q;
        exc_coll_d  = exc_coll_q;
        succ_d      = succ_q;
        fail_d      = fail_q;
        res_task_d  = res_task_q;
        res_coll_d  = res_coll_q;
        res_succ_d  = res_succ_q;
        res_fail_d  = res_fail_q;

        // Any cycle that is not a stall (including a completion) leaves the
        // counter at zero, so every new transfer starts counting from zero.
        if (xfer_stall) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (irq) begin
                    state_d = S_RD_EXC;
                end else if (cfg_valid) begin
                    cfg_task_d  = cfg_task;
                    cfg_start_d = cfg_start;
                    cfg_end_d   = cfg_end;
                    state_d     = S_WR_END;
                end
            end
            S_WR_END: begin
                if (xfer_done) begin
                    state_d  = S_WR_START;
                    bubble_d = 1'b1;
                end
            end
            S_WR_START: begin
                if (xfer_done) begin
                    state_d = S_GAP;
                end
            end
            S_RD_EXC: begin
                if (xfer_done) begin
                    exc_task_d = av_readdata[KEY_W-1:0];
                    exc_coll_d = av_readdata[EXC_EX_BIT];
                    state_d    = S_RD_SUCC;
                    bubble_d   = 1'b1;
                end
            end
            S_RD_SUCC: begin
                if (xfer_done) begin
                    succ_d   = av_readdata[NT-1:0];
                    state_d  = S_RD_FAIL;
                    bubble_d = 1'b1;
                end
            end
            S_RD_FAIL: begin
                if (xfer_done) begin
                    fail_d   = av_readdata[NT-1:0];
                    state_d  = S_WR_CLR;
                    bubble_d = 1'b1;
                end
            end
            S_WR_CLR: begin
                if (xfer_done) begin
                    res_task_d = exc_task_q;
                    res_coll_d = exc_coll_q;
                    res_succ_d = succ_q;
                    res_fail_d = fail_q;
                    state_d    = S_REPORT;
                end
            end
            S_REPORT: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abandon whatever transfer is stuck; an accepted config or an
        // in-progress service is simply dropped.
        if (timeout_hit) begin
            state_d  = S_GAP;
            bubble_d = 1'b0;
            err_d    = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        xfer_active  = 1'b0;
        av_read      = 1'b0;
        av_write     = 1'b0;
        av_address   = '0;
        av_writedata = '0;
        res_valid    = 1'b0;
        cfg_ready    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cfg_ready = reset_n && !irq && cfg_valid;
            end
            S_WR_END: begin
                av_write     = !bubble_q;
                av_address   = END_BASE + ADDR_W'(cfg_task_q);
                av_writedata = DATA_W'(cfg_end_q);
            end
            S_WR_START: begin
                av_write     = !bubble_q;
                av_address   = START_BASE + ADDR_W'(cfg_task_q);
                av_writedata = DATA_W'(cfg_start_q);
            end
            S_RD_EXC: begin
                av_read    = !bubble_q;
                av_address = EXC_OFF;
            end
            S_RD_SUCC: begin
                av_read    = !bubble_q;
                av_address = SUCC_OFF;
            end
            S_RD_FAIL: begin
                av_read    = !bubble_q;
                av_address = FAIL_OFF;
            end
            S_WR_CLR: begin
                av_write     = !bubble_q;
                av_address   = EXC_OFF;
                av_writedata = '0;
            end
            S_REPORT: begin
                res_valid = 1'b1;
            end
            default: begin
            end
        endcase

        xfer_active = av_read || av_write;
    end

    assign res_task      = res_task_q;
    assign res_collision = res_coll_q;
    assign res_succ_vec  = res_succ_q;
    assign res_fail_vec  = res_fail_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_comp_csr_master.sv
// ---------------------------------------------------------------------------
// tb_comp_csr_master
//
// Bench for comp_csr_master. A small Avalon slave model with programmable
// waitrequest holds the comparator registers; irq follows a nonzero exception
// register. Expected transfers and results are queued as stimulus is driven
// and compared against what the monitor records at each completion.
// ---------------------------------------------------------------------------
module tb_comp_csr_master;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct packed {
        logic [3:0]  tsk;
        logic        coll;
        logic [15:0] succ;
        logic [15:0] fail;
    } res_t;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [3:0]  cfg_task  = 4'h0;
    logic [9:0]  cfg_start = 10'h0;
    logic [9:0]  cfg_end   = 10'h0;
    logic        irq;
    logic [7:0]  av_address;
    logic        av_read;
    logic        av_write;
    logic [31:0] av_writedata;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic        res_valid;
    logic [3:0]  res_task;
    logic        res_collision;
    logic [15:0] res_succ_vec;
    logic [15:0] res_fail_vec;
    logic        err_timeout;

    always #5 clk = ~clk;

    comp_csr_master dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_task       (cfg_task),
        .cfg_start      (cfg_start),
        .cfg_end        (cfg_end),
        .irq            (irq),
        .av_address     (av_address),
        .av_read        (av_read),
        .av_write       (av_write),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest),
        .res_valid      (res_valid),
        .res_task       (res_task),
        .res_collision  (res_collision),
        .res_succ_vec   (res_succ_vec),
        .res_fail_vec   (res_fail_vec),
        .err_timeout    (err_timeout)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- slave model ----------------
    logic [31:0] regs [0:255];
    int          wait_cycles = 0;
    logic        stuck       = 1'b0;
    logic        irq_en      = 1'b0;
    int          stall_cnt   = 0;

    assign irq            = irq_en && (regs[0] != 32'h0);
    assign av_waitrequest = stuck || ((av_read || av_write) && (stall_cnt < wait_cycles));
    assign av_readdata    = regs[av_address];

    initial begin
        for (int i = 0; i < 256; i++) regs[i] <= 32'h0;
    end

    always @(posedge clk) begin
        if ((av_read || av_write) && av_waitrequest) stall_cnt <= stall_cnt + 1;
        else                                         stall_cnt <= 0;
        if (reset_n && av_write && !av_waitrequest) regs[av_address] <= av_writedata;
    end

    // ---------------- monitor ----------------
    xfer_t obs_x[$];
    res_t  obs_res[$];
    int    obs_rd    = 0;
    int    res_rd    = 0;
    int    cfg_acc   = 0;
    int    proto_err = 0;
    xfer_t cur_x;
    xfer_t prev_x     = '0;
    logic  prev_stall = 1'b0;
    logic  prev_done  = 1'b0;

    assign cur_x = {av_write, av_address, (av_write ? av_writedata : 32'h0)};

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall <= 1'b0;
            prev_done  <= 1'b0;
        end else begin
            if (av_read && av_write) begin
                proto_err++;
                $display("proto error: read and write both high at %0t", $time);
            end
            if (prev_done && (av_read || av_write)) begin
                proto_err++;
                $display("proto error: no idle cycle after completion at %0t", $time);
            end
            if (prev_stall && (av_read || av_write) && (cur_x !== prev_x)) begin
                proto_err++;
                $display("proto error: request changed during stall at %0t: %h -> %h", $time, prev_x, cur_x);
            end
            if ((av_read || av_write) && !av_waitrequest) begin
                obs_x.push_back(cur_x);
                $display("xfer %s addr=%h data=%h t=%0t", av_write ? "WR" : "RD", av_address,
                         av_write ? av_writedata : av_readdata, $time);
            end
            if (res_valid) begin
                obs_res.push_back({res_task, res_collision, res_succ_vec, res_fail_vec});
                $display("result task=%0d coll=%0d succ=%h fail=%h t=%0t", res_task, res_collision,
                         res_succ_vec, res_fail_vec, $time);
            end
            if (cfg_ready) cfg_acc++;
            prev_stall <= (av_read || av_write) && av_waitrequest;
            prev_done  <= (av_read || av_write) && !av_waitrequest;
            prev_x     <= cur_x;
        end
    end

    xfer_t exp_x[$];
    res_t  exp_res[$];

    function automatic xfer_t mk(input logic we, input logic [7:0] a, input logic [31:0] d);
        return {we, a, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_cfg(input logic [3:0] t, input logic [9:0] s, input logic [9:0] e,
                             output logic seen);
        int n;
        cfg_task  = t;
        cfg_start = s;
        cfg_end   = e;
        cfg_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        seen = cfg_ready;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        @(negedge clk);
        checks++;
        if ({av_read, av_write} !== 2'b00) begin
            failures++;
            $display("FAIL reset_strobes: got %b required 00", {av_read, av_write});
        end
        checks++;
        if (av_address !== 8'h00 || av_writedata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: got addr=%h data=%h required 0", av_address, av_writedata);
        end
        checks++;
        if ({res_valid, res_task, res_collision, res_succ_vec, res_fail_vec} !== 38'h0) begin
            failures++;
            $display("FAIL reset_result: got valid=%b task=%h coll=%b succ=%h fail=%h required 0",
                     res_valid, res_task, res_collision, res_succ_vec, res_fail_vec);
        end
        checks++;
        if ({err_timeout, cfg_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags: got err=%b ready=%b required 00", err_timeout, cfg_ready);
        end
        tick(1);
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_config();
        xfer_t e;
        xfer_t o;
        logic  seen;
        int    acc0 = cfg_acc;
        int    p0   = proto_err;
        wait_cycles = 2;
        exp_x.push_back(mk(1'b1, 8'h23, 32'h0000007F));
        exp_x.push_back(mk(1'b1, 8'h13, 32'h00000040));
        drive_cfg(4'd3, 10'h040, 10'h07F, seen);
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL cfg_ready_seen: got %b required 1", seen);
        end
        tick(30);
        while (exp_x.size() > 0) begin
            e = exp_x.pop_front();
            checks++;
            if (obs_rd >= obs_x.size()) begin
                failures++;
                $display("FAIL cfg_xfer: got none required %h", e);
            end else begin
                o = obs_x[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL cfg_xfer: got %h required %h", o, e);
                end
            end
        end
        checks++;
        if (obs_x.size() !== obs_rd) begin
            failures++;
            $display("FAIL cfg_extra_xfer: got %0d extra required 0", obs_x.size() - obs_rd);
            obs_rd = obs_x.size();
        end
        checks++;
        if (cfg_acc - acc0 !== 1) begin
            failures++;
            $display("FAIL cfg_ready_cycles: got %0d required 1", cfg_acc - acc0);
        end
        checks++;
        if (regs[8'h23] !== 32'h7F || regs[8'h13] !== 32'h40) begin
            failures++;
            $display("FAIL cfg_regs: got end=%h start=%h required 7f 40", regs[8'h23], regs[8'h13]);
        end
        checks++;
        if (proto_err !== p0) begin
            failures++;
            $display("FAIL cfg_protocol: got %0d violations required 0", proto_err - p0);
        end
    endtask

    task automatic test_irq_service();
        xfer_t e;
        xfer_t o;
        res_t  r;
        int    p0 = proto_err;
        wait_cycles = 2;
        regs[0] <= 32'h13;
        regs[1] <= 32'h0000;
        regs[2] <= 32'h0008;
        tick(1);
        exp_x.push_back(mk(1'b0, 8'h00, 32'h0));
        exp_x.push_back(mk(1'b0, 8'h01, 32'h0));
        exp_x.push_back(mk(1'b0, 8'h02, 32'h0));
        exp_x.push_back(mk(1'b1, 8'h00, 32'h0));
        exp_res.push_back({4'd3, 1'b1, 16'h0000, 16'h0008});
        irq_en = 1'b1;
        tick(50);
        while (exp_x.size() > 0) begin
            e = exp_x.pop_front();
            checks++;
            if (obs_rd >= obs_x.size()) begin
                failures++;
                $display("FAIL irq_xfer: got none required %h", e);
            end else begin
                o = obs_x[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL irq_xfer: got %h required %h", o, e);
                end
            end
        end
        checks++;
        if (obs_x.size() !== obs_rd) begin
            failures++;
            $display("FAIL irq_extra_xfer: got %0d extra required 0", obs_x.size() - obs_rd);
            obs_rd = obs_x.size();
        end
        while (exp_res.size() > 0) begin
            r = exp_res.pop_front();
            checks++;
            if (res_rd >= obs_res.size()) begin
                failures++;
                $display("FAIL irq_result: got none required %h", r);
            end else begin
                if (obs_res[res_rd] !== r) begin
                    failures++;
                    $display("FAIL irq_result: got %h required %h", obs_res[res_rd], r);
                end
                res_rd++;
            end
        end
        checks++;
        if (obs_res.size() !== res_rd) begin
            failures++;
            $display("FAIL irq_extra_result: got %0d extra required 0", obs_res.size() - res_rd);
            res_rd = obs_res.size();
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_cleared: got %b required 0", irq);
        end
        checks++;
        if (res_task !== 4'd3 || res_fail_vec !== 16'h0008) begin
            failures++;
            $display("FAIL irq_result_hold: got task=%h fail=%h required 3 0008", res_task, res_fail_vec);
        end
        checks++;
        if (proto_err !== p0) begin
            failures++;
            $display("FAIL irq_protocol: got %0d violations required 0", proto_err - p0);
        end
        irq_en = 1'b0;
    endtask

    task automatic test_irq_cfg_priority();
        xfer_t e;
        xfer_t o;
        res_t  r;
        logic  seen;
        int    res_before;
        int    p0 = proto_err;
        wait_cycles = 1;
        regs[0] <= 32'h25;
        regs[1] <= 32'h0020;
        regs[2] <= 32'h0000;
        tick(1);
        exp_x.push_back(mk(1'b0, 8'h00, 32'h0));
        exp_x.push_back(mk(1'b0, 8'h01, 32'h0));
        exp_x.push_back(mk(1'b0, 8'h02, 32'h0));
        exp_x.push_back(mk(1'b1, 8'h00, 32'h0));
        exp_x.push_back(mk(1'b1, 8'h27, 32'h00000001));
        exp_x.push_back(mk(1'b1, 8'h17, 32'h000003FF));
        exp_res.push_back({4'd5, 1'b0, 16'h0020, 16'h0000});
        res_before = obs_res.size();
        irq_en = 1'b1;
        drive_cfg(4'd7, 10'h3FF, 10'h001, seen);
        checks++;
        if (seen !== 1'b1 || obs_res.size() - res_before !== 1) begin
            failures++;
            $display("FAIL prio_accept_after_service: got seen=%b results=%0d required 1 1",
                     seen, obs_res.size() - res_before);
        end
        tick(30);
        while (exp_x.size() > 0) begin
            e = exp_x.pop_front();
            checks++;
            if (obs_rd >= obs_x.size()) begin
                failures++;
                $display("FAIL prio_xfer: got none required %h", e);
            end else begin
                o = obs_x[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL prio_xfer: got %h required %h", o, e);
                end
            end
        end
        checks++;
        if (obs_x.size() !== obs_rd) begin
            failures++;
            $display("FAIL prio_extra_xfer: got %0d extra required 0", obs_x.size() - obs_rd);
            obs_rd = obs_x.size();
        end
        while (exp_res.size() > 0) begin
            r = exp_res.pop_front();
            checks++;
            if (res_rd >= obs_res.size()) begin
                failures++;
                $display("FAIL prio_result: got none required %h", r);
            end else begin
                if (obs_res[res_rd] !== r) begin
                    failures++;
                    $display("FAIL prio_result: got %h required %h", obs_res[res_rd], r);
                end
                res_rd++;
            end
        end
        checks++;
        if (proto_err !== p0) begin
            failures++;
            $display("FAIL prio_protocol: got %0d violations required 0", proto_err - p0);
        end
        irq_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        xfer_t e;
        xfer_t o;
        logic  seen_a;
        logic  seen_b;
        int    p0 = proto_err;
        wait_cycles = 0;
        exp_x.push_back(mk(1'b1, 8'h2A, 32'h00000155));
        exp_x.push_back(mk(1'b1, 8'h1A, 32'h000000AA));
        exp_x.push_back(mk(1'b1, 8'h2F, 32'h00000200));
        exp_x.push_back(mk(1'b1, 8'h1F, 32'h00000100));
        drive_cfg(4'hA, 10'h0AA, 10'h155, seen_a);
        drive_cfg(4'hF, 10'h100, 10'h200, seen_b);
        checks++;
        if ({seen_a, seen_b} !== 2'b11) begin
            failures++;
            $display("FAIL b2b_accepts: got %b required 11", {seen_a, seen_b});
        end
        tick(20);
        while (exp_x.size() > 0) begin
            e = exp_x.pop_front();
            checks++;
            if (obs_rd >= obs_x.size()) begin
                failures++;
                $display("FAIL b2b_xfer: got none required %h", e);
            end else begin
                o = obs_x[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL b2b_xfer: got %h required %h", o, e);
                end
            end
        end
        checks++;
        if (obs_x.size() !== obs_rd) begin
            failures++;
            $display("FAIL b2b_extra_xfer: got %0d extra required 0", obs_x.size() - obs_rd);
            obs_rd = obs_x.size();
        end
        checks++;
        if (proto_err !== p0) begin
            failures++;
            $display("FAIL b2b_protocol: got %0d violations required 0", proto_err - p0);
        end
    endtask

    task automatic test_timeout();
        int   n;
        int   cnt;
        int   res_before;
        int   p0 = proto_err;
        logic seen;
        xfer_t e;
        xfer_t o;
        wait_cycles = 0;
        stuck       = 1'b1;
        regs[0] <= 32'h1;
        tick(1);
        res_before = obs_res.size();
        irq_en = 1'b1;
        n = 0;
        @(negedge clk);
        while (!av_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        cnt = 0;
        while (av_read && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        irq_en = 1'b0;
        stuck  = 1'b0;
        checks++;
        if (cnt !== 255) begin
            failures++;
            $display("FAIL timeout_stall_cycles: got %0d required 255", cnt);
        end
        checks++;
        if (err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_flag: got %b required 1", err_timeout);
        end
        tick(10);
        @(negedge clk);
        checks++;
        if ({av_read, av_write} !== 2'b00 || obs_x.size() !== obs_rd) begin
            failures++;
            $display("FAIL timeout_idle: got strobes=%b xfers=%0d required 00 0",
                     {av_read, av_write}, obs_x.size() - obs_rd);
            obs_rd = obs_x.size();
        end
        checks++;
        if (obs_res.size() !== res_before || regs[0] !== 32'h1) begin
            failures++;
            $display("FAIL timeout_no_result: got results=%0d exc=%h required 0 1",
                     obs_res.size() - res_before, regs[0]);
            res_rd = obs_res.size();
        end
        regs[0] <= 32'h0;
        tick(1);
        exp_x.push_back(mk(1'b1, 8'h22, 32'h00000033));
        exp_x.push_back(mk(1'b1, 8'h12, 32'h00000011));
        drive_cfg(4'd2, 10'h011, 10'h033, seen);
        tick(10);
        while (exp_x.size() > 0) begin
            e = exp_x.pop_front();
            checks++;
            if (obs_rd >= obs_x.size()) begin
                failures++;
                $display("FAIL post_timeout_xfer: got none required %h", e);
            end else begin
                o = obs_x[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL post_timeout_xfer: got %h required %h", o, e);
                end
            end
        end
        checks++;
        if (seen !== 1'b1 || err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: got seen=%b err=%b required 1 1", seen, err_timeout);
        end
        checks++;
        if (proto_err !== p0) begin
            failures++;
            $display("FAIL timeout_protocol: got %0d violations required 0", proto_err - p0);
        end
    endtask

    task automatic test_reset_mid_service();
        int    n;
        xfer_t e;
        xfer_t o;
        res_t  r;
        wait_cycles = 5;
        regs[0] <= 32'h13;
        regs[1] <= 32'h0000;
        regs[2] <= 32'h0008;
        tick(1);
        exp_x.push_back(mk(1'b0, 8'h00, 32'h0));
        irq_en = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(av_read && av_address == 8'h01) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(av_read && av_address == 8'h01)) begin
            failures++;
            $display("FAIL rst_mid_reach_succ: got read=%b addr=%h required 1 01", av_read, av_address);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({av_read, av_write, res_valid, cfg_ready} !== 4'b0000 || av_address !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_strobes: got rd=%b wr=%b rv=%b rdy=%b addr=%h required 0",
                     av_read, av_write, res_valid, cfg_ready, av_address);
        end
        checks++;
        if ({err_timeout, res_task, res_collision, res_succ_vec, res_fail_vec} !== 38'h0) begin
            failures++;
            $display("FAIL rst_mid_regs: got err=%b task=%h coll=%b succ=%h fail=%h required 0",
                     err_timeout, res_task, res_collision, res_succ_vec, res_fail_vec);
        end
        tick(1);
        reset_n = 1'b1;
        exp_x.push_back(mk(1'b0, 8'h00, 32'h0));
        exp_x.push_back(mk(1'b0, 8'h01, 32'h0));
        exp_x.push_back(mk(1'b0, 8'h02, 32'h0));
        exp_x.push_back(mk(1'b1, 8'h00, 32'h0));
        exp_res.push_back({4'd3, 1'b1, 16'h0000, 16'h0008});
        tick(80);
        while (exp_x.size() > 0) begin
            e = exp_x.pop_front();
            checks++;
            if (obs_rd >= obs_x.size()) begin
                failures++;
                $display("FAIL rst_mid_xfer: got none required %h", e);
            end else begin
                o = obs_x[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL rst_mid_xfer: got %h required %h", o, e);
                end
            end
        end
        checks++;
        if (obs_x.size() !== obs_rd) begin
            failures++;
            $display("FAIL rst_mid_extra_xfer: got %0d extra required 0", obs_x.size() - obs_rd);
            obs_rd = obs_x.size();
        end
        while (exp_res.size() > 0) begin
            r = exp_res.pop_front();
            checks++;
            if (res_rd >= obs_res.size()) begin
                failures++;
                $display("FAIL rst_mid_result: got none required %h", r);
            end else begin
                if (obs_res[res_rd] !== r) begin
                    failures++;
                    $display("FAIL rst_mid_result: got %h required %h", obs_res[res_rd], r);
                end
                res_rd++;
            end
        end
        checks++;
        if (obs_res.size() !== res_rd) begin
            failures++;
            $display("FAIL rst_mid_extra_result: got %0d extra required 0", obs_res.size() - res_rd);
        end
        irq_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_config();
        test_irq_service();
        test_irq_cfg_priority();
        test_back_to_back();
        test_timeout();
        test_reset_mid_service();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
